// File: rtl/crypto1_pkg.sv
// +--------------------------------------------------------------------+
// | crypto1_pkg : shared types and constants for the Crypto1 scheduler |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package crypto1_pkg;

   localparam int KEY_W = 48;
   localparam int NJOBS = 256;

   typedef struct packed {
      logic [3:0] eidx;
      logic [3:0] oidx;
   } job_idx_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2
   } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/crypto1_key_fifo.sv
// +--------------------------------------------------------------------+
// | crypto1_key_fifo : first-word-fall-through candidate key FIFO      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module crypto1_key_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 48,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         not_empty,
   output logic         full
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign not_empty = (count != '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign do_pop    = pop && not_empty;
   assign do_push   = push && (!full || do_pop);
   assign dout      = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : round-robin picker, first request at/after pointer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] ptr;

   always_comb begin
      int pos;
      pos = 0;
      any = 1'b0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!any && req[IW'(pos)]) begin
            any = 1'b1;
            idx = IW'(pos);
         end
      end
   end

   // Pointer only moves when the caller actually consumes the pick.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (adv && any) begin
         ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/crypto1_attack_sched.sv
// +--------------------------------------------------------------------+
// | crypto1_attack_sched : job dispatcher and candidate-key collector  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module crypto1_attack_sched
   import crypto1_pkg::*;
#(
   parameter int NCORES     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int KEY_W      = crypto1_pkg::KEY_W
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    START,
   input  logic [KEY_W-1:0]        BITSTREAM_IN,
   output logic [KEY_W-1:0]        BITSTREAM,
   output logic [NCORES-1:0]       JOB_GNT,
   output logic [7:0]              JOB_IDX,
   input  logic [NCORES-1:0]       CORE_IDLE,
   input  logic [NCORES-1:0]       CAND_VALID,
   input  logic [NCORES*KEY_W-1:0] CAND_KEY,
   output logic [NCORES-1:0]       CAND_ACK,
   output logic                    KEY_VALID,
   output logic [KEY_W-1:0]        KEY,
   input  logic                    KEY_READY,
   output logic                    BUSY,
   output logic                    DONE,
   output logic [15:0]             CAND_COUNT
);

   localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

   sched_state_t      state;
   sched_state_t      state_nx;
   logic [8:0]        job_cnt;
   job_idx_t          job;
   logic [NCORES-1:0] pend;
   logic [NCORES-1:0] ack_r;
   logic              latch_start;
   logic              disp_en;
   logic              coll_en;
   logic              drain_done;
   logic [NCORES-1:0] disp_req;
   logic [NCORES-1:0] coll_req;
   logic [IW-1:0]     disp_idx;
   logic [IW-1:0]     coll_idx;
   logic              disp_any;
   logic              coll_any;
   logic              fifo_full;
   logic              pop;
   logic              push;
   logic [KEY_W-1:0]  push_key;

   assign job      = job_cnt[7:0];
   assign JOB_GNT  = pend;
   assign CAND_ACK = ack_r;
   assign BUSY     = (state != IDLE);

   // pend and ack_r hide a core's stale IDLE/VALID during the cycle it sees its grant/ack.
   assign disp_req = disp_en ? (CORE_IDLE & ~pend) : '0;
   assign coll_req = coll_en ? (CAND_VALID & ~ack_r) : '0;
   assign pop      = KEY_READY && KEY_VALID;
   assign push     = coll_any && (!fifo_full || pop);
   assign push_key = CAND_KEY[32'(coll_idx) * KEY_W +: KEY_W];

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      latch_start = 1'b0;
      disp_en     = 1'b0;
      coll_en     = 1'b0;
      drain_done  = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               latch_start = 1'b1;
               state_nx    = DISPATCH;
            end
         end
         DISPATCH: begin
            coll_en = 1'b1;
            if (job_cnt == 9'(NJOBS)) state_nx = DRAIN;
            else                      disp_en  = 1'b1;
         end
         DRAIN: begin
            coll_en = 1'b1;
            if ((&CORE_IDLE) && (pend == '0) && (CAND_VALID == '0)) begin
               drain_done = 1'b1;
               state_nx   = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         job_cnt    <= '0;
         pend       <= '0;
         ack_r      <= '0;
         BITSTREAM  <= '0;
         JOB_IDX    <= '0;
         DONE       <= 1'b0;
         CAND_COUNT <= '0;
      end else begin
         DONE  <= drain_done;
         pend  <= '0;
         ack_r <= '0;
         if (latch_start) begin
            BITSTREAM  <= BITSTREAM_IN;
            job_cnt    <= '0;
            CAND_COUNT <= '0;
         end
         if (disp_any) begin
            pend[disp_idx] <= 1'b1;
            JOB_IDX        <= job;
            job_cnt        <= job_cnt + 1'b1;
         end
         if (push) begin
            ack_r[coll_idx] <= 1'b1;
            if (CAND_COUNT != 16'hFFFF) CAND_COUNT <= CAND_COUNT + 1'b1;
         end
      end
   end

   rr_arbiter #(.N(NCORES)) u_disp_arb (
      .clk (CLK),
      .rst (RESET),
      .req (disp_req),
      .adv (1'b1),
      .idx (disp_idx),
      .any (disp_any)
   );

   rr_arbiter #(.N(NCORES)) u_coll_arb (
      .clk (CLK),
      .rst (RESET),
      .req (coll_req),
      .adv (push),
      .idx (coll_idx),
      .any (coll_any)
   );

   crypto1_key_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_W)) u_key_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .push      (push),
      .din       (push_key),
      .pop       (pop),
      .dout      (KEY),
      .not_empty (KEY_VALID),
      .full      (fifo_full)
   );

endmodule

`default_nettype wire
